// File: rtl/cache_port_arbiter.sv
// Cache port arbiter: per-port write FIFOs drained one entry per cycle into a
// single bank write port, plus unqueued per-port read address registration.
// Optional feature macro: CACHE_ARB_ROUND_ROBIN_EN selects round-robin write
// arbitration; without it the lowest-indexed non-empty FIFO always wins.
module cache_port_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_W     = 8,
    parameter int NET_W      = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*ADDR_W-1:0]   cacheAddressIn,
    input  logic [NUM_PORTS*NET_W-1:0]    requesterAddressIn,
    input  logic [NUM_PORTS-1:0]          memReadIn,
    input  logic [NUM_PORTS-1:0]          memWriteIn,
    input  logic [NUM_PORTS*DATA_W-1:0]   dataIn,
    output logic [NUM_PORTS-1:0]          readReady,
    output logic [NUM_PORTS*NET_W-1:0]    requesterAddressOut,
    output logic [NUM_PORTS-1:0]          writeFull,
    output logic [NUM_PORTS*ADDR_W-1:0]   cacheReadAddress,
    output logic [DATA_W-1:0]             cacheDataIn,
    output logic [ADDR_W-1:0]             cacheWriteAddressIn,
    output logic                          memRead,
    output logic                          memWrite
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // FIFO storage carries no reset: occupancy is governed by the counters.
    logic [ADDR_W-1:0] fifo_addr_q [NUM_PORTS][FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [NUM_PORTS][FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q  [NUM_PORTS];
    logic [PTR_W-1:0]  wr_ptr_d  [NUM_PORTS];
    logic [PTR_W-1:0]  rd_ptr_q  [NUM_PORTS];
    logic [PTR_W-1:0]  rd_ptr_d  [NUM_PORTS];
    logic [CNT_W-1:0]  count_q   [NUM_PORTS];
    logic [CNT_W-1:0]  count_d   [NUM_PORTS];

    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic                 grant_vld;
    logic [PORT_W-1:0]    grant_idx;
    logic [PORT_W-1:0]    search_idx;

    logic [NUM_PORTS-1:0]        read_ready_q;
    logic [NUM_PORTS*NET_W-1:0]  req_addr_q;
    logic [NUM_PORTS*ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0]           wr_data_q;
    logic [ADDR_W-1:0]           wr_addr_q;
    logic                        mem_read_q;
    logic                        mem_write_q;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic [PORT_W-1:0] rr_ptr_q;
    logic [PORT_W-1:0] rr_ptr_d;
`endif

    assign readReady           = read_ready_q;
    assign requesterAddressOut = req_addr_q;
    assign cacheReadAddress    = rd_addr_q;
    assign cacheDataIn         = wr_data_q;
    assign cacheWriteAddressIn = wr_addr_q;
    assign memRead             = mem_read_q;
    assign memWrite            = mem_write_q;

    // Backpressure straight from the registered occupancy count.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            writeFull[i] = (count_q[i] == CNT_W'(FIFO_DEPTH));
        end
    end

    // Pick at most one non-empty FIFO to pop this cycle.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        search_idx = '0;
        pop        = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            search_idx = PORT_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
`else
            search_idx = PORT_W'(k);
`endif
            if (!grant_vld && (count_q[search_idx] != '0)) begin
                grant_vld       = 1'b1;
                grant_idx       = search_idx;
                pop[search_idx] = 1'b1;
            end
        end
    end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // Search restarts just past the most recently granted port.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = PORT_W'((int'(grant_idx) + 1) % NUM_PORTS);
        end
    end
`endif

    // Next-state pointers and counts; push and pop may coincide.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            push[i]     = memWriteIn[i] && !writeFull[i];
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            count_d[i]  = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    // Capture accepted writes into each port's FIFO storage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) begin
                fifo_addr_q[i][wr_ptr_q[i]] <= cacheAddressIn[i*ADDR_W +: ADDR_W];
                fifo_data_q[i][wr_ptr_q[i]] <= dataIn[i*DATA_W +: DATA_W];
            end
        end
    end

    // FIFO control, arbitration state and registered bank outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            rr_ptr_q <= '0;
`endif
            read_ready_q <= '0;
            req_addr_q   <= '0;
            rd_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
                read_ready_q[i] <= memReadIn[i];
                if (memReadIn[i]) begin
                    rd_addr_q[i*ADDR_W +: ADDR_W] <= cacheAddressIn[i*ADDR_W +: ADDR_W];
                    req_addr_q[i*NET_W +: NET_W]  <= requesterAddressIn[i*NET_W +: NET_W];
                end
            end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            rr_ptr_q <= rr_ptr_d;
`endif
            mem_read_q  <= |memReadIn;
            mem_write_q <= grant_vld;
            if (grant_vld) begin
                wr_addr_q <= fifo_addr_q[grant_idx][rd_ptr_q[grant_idx]];
                wr_data_q <= fifo_data_q[grant_idx][rd_ptr_q[grant_idx]];
            end
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with a write scoreboard on the bank port.
// Round-robin expectations apply when CACHE_ARB_ROUND_ROBIN_EN is defined.
module tb_cache_port_arbiter;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   cacheAddressIn = '0;
    logic [15:0]   requesterAddressIn = '0;
    logic [3:0]    memReadIn = '0;
    logic [3:0]    memWriteIn = '0;
    logic [127:0]  dataIn = '0;
    logic [3:0]    readReady;
    logic [15:0]   requesterAddressOut;
    logic [3:0]    writeFull;
    logic [31:0]   cacheReadAddress;
    logic [31:0]   cacheDataIn;
    logic [7:0]    cacheWriteAddressIn;
    logic          memRead;
    logic          memWrite;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected bank writes as {addr, data}: one in-order queue for directed
    // steps, per-port queues (port encoded in addr[7:6]) for saturation.
    logic [39:0] exp_q [$];
    logic [39:0] port_q [4][$];
    logic        sat_mode = 1'b0;
    int          mp;
    logic [39:0] me;

    cache_port_arbiter dut (
        .clk                 (clk),
        .reset               (reset),
        .cacheAddressIn      (cacheAddressIn),
        .requesterAddressIn  (requesterAddressIn),
        .memReadIn           (memReadIn),
        .memWriteIn          (memWriteIn),
        .dataIn              (dataIn),
        .readReady           (readReady),
        .requesterAddressOut (requesterAddressOut),
        .writeFull           (writeFull),
        .cacheReadAddress    (cacheReadAddress),
        .cacheDataIn         (cacheDataIn),
        .cacheWriteAddressIn (cacheWriteAddressIn),
        .memRead             (memRead),
        .memWrite            (memWrite)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic [7:0] a, input logic [31:0] d);
        memWriteIn[p] = 1'b1;
        cacheAddressIn[p*8 +: 8] = a;
        dataIn[p*32 +: 32] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        memWriteIn = '0;
        memReadIn = '0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) port_q[i].delete();
        step();
        step();
        reset = 1'b0;
    endtask

    // Scoreboard: every bank write must match the next expected entry.
    always @(negedge clk) begin
        if (!reset && memWrite) begin
            if (sat_mode) begin
                mp = int'(cacheWriteAddressIn[7:6]);
                check("sb_port_pending", 64'(port_q[mp].size() != 0), 64'd1);
                if (port_q[mp].size() != 0) begin
                    me = port_q[mp].pop_front();
                    check("sb_sat_addr", 64'(cacheWriteAddressIn), 64'(me[39:32]));
                    check("sb_sat_data", 64'(cacheDataIn), 64'(me[31:0]));
                end
            end else begin
                check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    me = exp_q.pop_front();
                    check("sb_addr", 64'(cacheWriteAddressIn), 64'(me[39:32]));
                    check("sb_data", 64'(cacheDataIn), 64'(me[31:0]));
                end
            end
        end
    end

    initial begin
        int          seq [4];
        logic [3:0]  acc;
        logic [3:0]  seen_full;
        logic [7:0]  wa;
        logic [31:0] wd;
        int          exp_port;

        // Reset state
        step();
        step();
        check("rst_memWrite", 64'(memWrite), 64'd0);
        check("rst_memRead", 64'(memRead), 64'd0);
        check("rst_readReady", 64'(readReady), 64'd0);
        check("rst_writeFull", 64'(writeFull), 64'd0);
        check("rst_wr_addr", 64'(cacheWriteAddressIn), 64'd0);
        check("rst_wr_data", 64'(cacheDataIn), 64'd0);
        check("rst_rd_addr", 64'(cacheReadAddress), 64'd0);
        check("rst_req_out", 64'(requesterAddressOut), 64'd0);
        reset = 1'b0;

        // Single write: visible only after the second edge, then holds
        set_wr(0, 8'h02, 32'd10);
        exp_q.push_back({8'h02, 32'd10});
        step();
        memWriteIn = '0;
        check("w1_not_early", 64'(memWrite), 64'd0);
        step();
        check("w1_memWrite", 64'(memWrite), 64'd1);
        check("w1_addr", 64'(cacheWriteAddressIn), 64'h02);
        check("w1_data", 64'(cacheDataIn), 64'd10);
        step();
        check("w1_idle", 64'(memWrite), 64'd0);
        check("w1_addr_hold", 64'(cacheWriteAddressIn), 64'h02);
        check("w1_data_hold", 64'(cacheDataIn), 64'd10);

        // Two ports write together: port 0 first, port 1 next cycle
        do_reset();
        set_wr(0, 8'h03, 32'd5);
        set_wr(1, 8'h01, 32'd4);
        exp_q.push_back({8'h03, 32'd5});
        exp_q.push_back({8'h01, 32'd4});
        step();
        memWriteIn = '0;
        step();
        check("w2_first_addr", 64'(cacheWriteAddressIn), 64'h03);
        check("w2_first_data", 64'(cacheDataIn), 64'd5);
        step();
        check("w2_second_vld", 64'(memWrite), 64'd1);
        check("w2_second_addr", 64'(cacheWriteAddressIn), 64'h01);
        check("w2_second_data", 64'(cacheDataIn), 64'd4);
        step();
        check("w2_idle", 64'(memWrite), 64'd0);

        // Reads: port 3 plain read, port 1 read and write together
        memReadIn[3] = 1'b1;
        cacheAddressIn[24 +: 8] = 8'h06;
        requesterAddressIn[12 +: 4] = 4'h9;
        memReadIn[1] = 1'b1;
        set_wr(1, 8'h11, 32'h77);
        exp_q.push_back({8'h11, 32'h77});
        step();
        memReadIn = '0;
        memWriteIn = '0;
        check("rd_ready", 64'(readReady), 64'b1010);
        check("rd_addr3", 64'(cacheReadAddress[24 +: 8]), 64'h06);
        check("rd_req3", 64'(requesterAddressOut[12 +: 4]), 64'h9);
        check("rd_addr1", 64'(cacheReadAddress[8 +: 8]), 64'h11);
        check("rd_memRead", 64'(memRead), 64'd1);
        check("rd_wr_pending", 64'(memWrite), 64'd0);
        step();
        check("rd_ready_clr", 64'(readReady), 64'd0);
        check("rd_memRead_clr", 64'(memRead), 64'd0);
        check("rd_addr3_hold", 64'(cacheReadAddress[24 +: 8]), 64'h06);
        check("rw_memWrite", 64'(memWrite), 64'd1);
        check("rw_addr", 64'(cacheWriteAddressIn), 64'h11);
        step();

        // Reset with three queued writes discards them
        set_wr(0, 8'h21, 32'd1);
        set_wr(1, 8'h22, 32'd2);
        set_wr(2, 8'h23, 32'd3);
        memReadIn[0] = 1'b1;
        step();
        memWriteIn = '0;
        memReadIn = '0;
        check("mr_read_before", 64'(readReady[0]), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mr_readReady", 64'(readReady), 64'd0);
        check("mr_wr_addr", 64'(cacheWriteAddressIn), 64'd0);
        check("mr_wr_data", 64'(cacheDataIn), 64'd0);
        check("mr_rd_addr", 64'(cacheReadAddress), 64'd0);
        check("mr_req_out", 64'(requesterAddressOut), 64'd0);
        check("mr_memWrite", 64'(memWrite), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            check("mr_no_write", 64'(memWrite), 64'd0);
        end

        // Saturation: every port writes every cycle, retrying while full
        do_reset();
        sat_mode = 1'b1;
        seen_full = '0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        for (int c = 1; c <= 12; c++) begin
            for (int i = 0; i < 4; i++) begin
                wa = {2'(i), 6'(seq[i])};
                wd = 32'(i * 1000 + seq[i]);
                set_wr(i, wa, wd);
                acc[i] = !writeFull[i];
            end
            step();
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    port_q[i].push_back({cacheAddressIn[i*8 +: 8], dataIn[i*32 +: 32]});
                    seq[i]++;
                end
            end
            seen_full |= writeFull;
            if (c >= 2) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                exp_port = (c - 2) % 4;
`else
                exp_port = 0;
`endif
                check("sat_memWrite", 64'(memWrite), 64'd1);
                check("sat_grant", 64'(cacheWriteAddressIn[7:6]), 64'(exp_port));
            end
        end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        check("sat_full_seen", 64'(seen_full), 64'hF);
`else
        check("sat_full_starve", 64'(writeFull), 64'b1110);
`endif
        memWriteIn = '0;
        repeat (30) step();
        for (int i = 0; i < 4; i++) begin
            check("sat_drained", 64'(port_q[i].size()), 64'd0);
        end
        check("sat_idle", 64'(memWrite), 64'd0);
        check("sat_not_full", 64'(writeFull), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
